// File: rtl/reg_access_ctrl.sv
// Initiator-side controller for register_block: arbitrates issue reads against
// execute writebacks on the shared warp selector and registers operand bundles.
module reg_access_ctrl #(
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned WARP_W       = 3,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // operand-read requests from issue
  input  logic                          iss_valid,
  output logic                          iss_ready,
  input  logic [WARP_W-1:0]             iss_warp,
  input  logic [NUM_LANES-1:0]          iss_mask,
  input  logic [ADDR_W-1:0]             iss_rs0,
  input  logic [ADDR_W-1:0]             iss_rs1,
  input  logic                          iss_rs0_en,
  input  logic                          iss_rs1_en,
  // writeback requests from execute
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [WARP_W-1:0]             wb_warp,
  input  logic [NUM_LANES-1:0]          wb_mask,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [NUM_LANES*DATA_W-1:0]   wb_data,
  // register_block ports
  output logic [NUM_LANES-1:0]          rb_read_en_0,
  output logic [NUM_LANES-1:0]          rb_read_en_1,
  output logic [ADDR_W-1:0]             rb_raddr_0,
  output logic [ADDR_W-1:0]             rb_raddr_1,
  output logic [NUM_LANES-1:0]          rb_write_en,
  output logic [ADDR_W-1:0]             rb_waddr,
  output logic [NUM_LANES*DATA_W-1:0]   rb_wdata,
  output logic [WARP_W-1:0]             rb_warp_selector,
  input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_0,
  input  logic [NUM_LANES*DATA_W-1:0]   rb_rdata_1,
  // operand bundle to execute
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [WARP_W-1:0]             op_warp,
  output logic [NUM_LANES-1:0]          op_mask,
  output logic [NUM_LANES*DATA_W-1:0]   op_data_0,
  output logic [NUM_LANES*DATA_W-1:0]   op_data_1
);

  localparam int unsigned BUS_W = NUM_LANES * DATA_W;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic               slot_free_c;
  logic               same_warp_c;
  logic               conflict_c;
  logic               starve_hit_c;
  logic               wb_grant_c;
  logic               rd_grant_c;
  logic               bypass_0_c;
  logic               bypass_1_c;
  logic [CNT_W-1:0]   starve_cnt;
  logic [CNT_W-1:0]   starve_cnt_nxt_c;
  logic [WARP_W-1:0]  last_warp;
  logic [BUS_W-1:0]   cap_data_0_c;
  logic [BUS_W-1:0]   cap_data_1_c;

  // Per-lane operand select: masked-off lanes and unused ports read as zero,
  // same-cycle granted writes to the same register are forwarded.
  function automatic logic [BUS_W-1:0] capture(
    input logic                 port_en,
    input logic                 bypass,
    input logic [NUM_LANES-1:0] rd_mask,
    input logic [NUM_LANES-1:0] wr_mask,
    input logic [BUS_W-1:0]     wr_data,
    input logic [BUS_W-1:0]     rdata
  );
    logic [BUS_W-1:0] lanes;
    lanes = '0;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (port_en && rd_mask[l]) begin
        lanes[l*DATA_W +: DATA_W] = (bypass && wr_mask[l]) ? wr_data[l*DATA_W +: DATA_W]
                                                           : rdata[l*DATA_W +: DATA_W];
      end
    end
    return lanes;
  endfunction

  // Arbitration: writes win unless a cross-warp read has starved long enough.
  always_comb begin
    slot_free_c  = !op_valid || op_ready;
    same_warp_c  = (wb_warp == iss_warp);
    conflict_c   = wb_valid && iss_valid && slot_free_c && !same_warp_c;
    starve_hit_c = conflict_c && (starve_cnt == CNT_W'(STARVE_LIMIT));
    wb_grant_c   = !rst && wb_valid && !starve_hit_c;
    rd_grant_c   = !rst && iss_valid && slot_free_c && (!wb_grant_c || same_warp_c);
  end

  always_comb begin
    starve_cnt_nxt_c = '0;
    if (conflict_c && !rd_grant_c) begin
      starve_cnt_nxt_c = (starve_cnt == CNT_W'(STARVE_LIMIT)) ? starve_cnt
                                                             : starve_cnt + CNT_W'(1);
    end
  end

  // Register-block drive
  always_comb begin
    iss_ready    = rd_grant_c;
    wb_ready     = wb_grant_c;
    rb_write_en  = wb_grant_c ? wb_mask : '0;
    rb_waddr     = wb_addr;
    rb_wdata     = wb_data;
    rb_read_en_0 = (rd_grant_c && iss_rs0_en) ? iss_mask : '0;
    rb_read_en_1 = (rd_grant_c && iss_rs1_en) ? iss_mask : '0;
    rb_raddr_0   = iss_rs0;
    rb_raddr_1   = iss_rs1;
    if (wb_grant_c) begin
      rb_warp_selector = wb_warp;
    end else if (rd_grant_c) begin
      rb_warp_selector = iss_warp;
    end else begin
      rb_warp_selector = last_warp;
    end
  end

  always_comb begin
    bypass_0_c   = wb_grant_c && same_warp_c && (wb_addr == iss_rs0);
    bypass_1_c   = wb_grant_c && same_warp_c && (wb_addr == iss_rs1);
    cap_data_0_c = capture(iss_rs0_en, bypass_0_c, iss_mask, wb_mask, wb_data, rb_rdata_0);
    cap_data_1_c = capture(iss_rs1_en, bypass_1_c, iss_mask, wb_mask, wb_data, rb_rdata_1);
  end

  // Starvation counter, warp-selector hold value and one-entry output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      last_warp  <= '0;
      op_valid   <= 1'b0;
      op_warp    <= '0;
      op_mask    <= '0;
      op_data_0  <= '0;
      op_data_1  <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt_c;
      if (wb_grant_c) begin
        last_warp <= wb_warp;
      end else if (rd_grant_c) begin
        last_warp <= iss_warp;
      end
      if (rd_grant_c) begin
        op_valid  <= 1'b1;
        op_warp   <= iss_warp;
        op_mask   <= iss_mask;
        op_data_0 <= cap_data_0_c;
        op_data_1 <= cap_data_1_c;
      end else if (op_ready) begin
        op_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: register_block model, vector table with expected
// grants, and a bundle scoreboard fed from a bench-owned reference memory.
module tb_reg_access_ctrl;

  localparam int unsigned NL = 16;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int unsigned WW = 3;
  localparam int unsigned BW = NL * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid, iss_ready, iss_rs0_en, iss_rs1_en;
  logic [WW-1:0] iss_warp;
  logic [NL-1:0] iss_mask;
  logic [AW-1:0] iss_rs0, iss_rs1;
  logic          wb_valid, wb_ready;
  logic [WW-1:0] wb_warp;
  logic [NL-1:0] wb_mask;
  logic [AW-1:0] wb_addr;
  logic [BW-1:0] wb_data;
  logic [NL-1:0] rb_read_en_0, rb_read_en_1, rb_write_en;
  logic [AW-1:0] rb_raddr_0, rb_raddr_1, rb_waddr;
  logic [BW-1:0] rb_wdata, rb_rdata_0, rb_rdata_1;
  logic [WW-1:0] rb_warp_selector;
  logic          op_valid, op_ready;
  logic [WW-1:0] op_warp;
  logic [NL-1:0] op_mask;
  logic [BW-1:0] op_data_0, op_data_1;

  typedef struct {
    logic          wb_v;
    logic [WW-1:0] wb_w;
    logic [AW-1:0] wb_a;
    logic [NL-1:0] wb_m;
    logic [BW-1:0] wb_d;
    logic          iss_v;
    logic [WW-1:0] iss_w;
    logic [AW-1:0] rs0, rs1;
    logic          en0, en1;
    logic [NL-1:0] iss_m;
    logic          op_rdy;
    logic          exp_wb, exp_iss;
    logic [WW-1:0] exp_sel;
  } vec_t;

  typedef struct {
    logic [WW-1:0] warp;
    logic [NL-1:0] mask;
    logic [BW-1:0] d0, d1;
  } bundle_t;

  int            n_vec = 0;
  int            n_err = 0;
  bundle_t       sb[$];
  vec_t          tbl[$];
  logic          mem_init = 1'b0;
  logic [DW-1:0] mem     [8][64][NL];
  logic [DW-1:0] ref_mem [8][64][NL];

  always #5 clk = ~clk;

  reg_access_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_warp(iss_warp), .iss_mask(iss_mask),
    .iss_rs0(iss_rs0), .iss_rs1(iss_rs1), .iss_rs0_en(iss_rs0_en), .iss_rs1_en(iss_rs1_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_warp(wb_warp), .wb_mask(wb_mask),
    .wb_addr(wb_addr), .wb_data(wb_data),
    .rb_read_en_0(rb_read_en_0), .rb_read_en_1(rb_read_en_1),
    .rb_raddr_0(rb_raddr_0), .rb_raddr_1(rb_raddr_1),
    .rb_write_en(rb_write_en), .rb_waddr(rb_waddr), .rb_wdata(rb_wdata),
    .rb_warp_selector(rb_warp_selector), .rb_rdata_0(rb_rdata_0), .rb_rdata_1(rb_rdata_1),
    .op_valid(op_valid), .op_ready(op_ready), .op_warp(op_warp), .op_mask(op_mask),
    .op_data_0(op_data_0), .op_data_1(op_data_1)
  );

  function automatic logic [DW-1:0] init_val(input int w, input int a, input int l);
    return 32'hC000_0000 | 32'(w << 16) | 32'(a << 8) | 32'(l);
  endfunction

  // register_block: combinational reads, writes at the rising edge
  always_ff @(posedge clk) begin
    if (mem_init) begin
      for (int w = 0; w < 8; w++)
        for (int a = 0; a < 64; a++)
          for (int l = 0; l < NL; l++) mem[w][a][l] <= init_val(w, a, l);
    end else begin
      for (int l = 0; l < NL; l++)
        if (rb_write_en[l]) mem[rb_warp_selector][rb_waddr][l] <= rb_wdata[l*DW +: DW];
    end
  end

  always_comb begin
    rb_rdata_0 = '0;
    rb_rdata_1 = '0;
    for (int l = 0; l < NL; l++) begin
      rb_rdata_0[l*DW +: DW] = mem[rb_warp_selector][rb_raddr_0][l];
      rb_rdata_1[l*DW +: DW] = mem[rb_warp_selector][rb_raddr_1][l];
    end
  end

  function automatic logic [BW-1:0] fill(input logic [DW-1:0] base, input logic inc);
    logic [BW-1:0] r;
    for (int l = 0; l < NL; l++) r[l*DW +: DW] = inc ? base + 32'(l) : base;
    return r;
  endfunction

  function automatic vec_t mk(
    input logic wb_v, input logic [WW-1:0] wb_w, input logic [AW-1:0] wb_a,
    input logic [NL-1:0] wb_m, input logic [BW-1:0] wb_d,
    input logic iss_v, input logic [WW-1:0] iss_w, input logic [AW-1:0] rs0,
    input logic [AW-1:0] rs1, input logic en0, input logic en1, input logic [NL-1:0] iss_m,
    input logic op_rdy, input logic exp_wb, input logic exp_iss, input logic [WW-1:0] exp_sel);
    vec_t v;
    v.wb_v = wb_v;   v.wb_w = wb_w;   v.wb_a = wb_a;   v.wb_m = wb_m;   v.wb_d = wb_d;
    v.iss_v = iss_v; v.iss_w = iss_w; v.rs0 = rs0;     v.rs1 = rs1;
    v.en0 = en0;     v.en1 = en1;     v.iss_m = iss_m; v.op_rdy = op_rdy;
    v.exp_wb = exp_wb; v.exp_iss = exp_iss; v.exp_sel = exp_sel;
    return v;
  endfunction

  function automatic vec_t idle(input logic [WW-1:0] sel);
    return mk(1'b0, 3'd0, 6'd0, 16'h0, '0, 1'b0, 3'd0, 6'd0, 6'd0, 1'b0, 1'b0, 16'h0,
              1'b1, 1'b0, 1'b0, sel);
  endfunction

  function automatic vec_t conflict_vec(input logic read_wins);
    return mk(1'b1, 3'd1, 6'h07, 16'hFFFF, fill(32'h7777_0000, 1'b1),
              1'b1, 3'd6, 6'h01, 6'h02, 1'b1, 1'b1, 16'hFFFF,
              1'b1, !read_wins, read_wins, read_wins ? 3'd6 : 3'd1);
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected operand from the reference memory with same-cycle forwarding
  function automatic logic [BW-1:0] expect_port(input vec_t v, input logic [AW-1:0] rs,
                                                input logic en);
    logic [BW-1:0] r;
    r = '0;
    for (int l = 0; l < NL; l++) begin
      if (en && v.iss_m[l]) begin
        if (v.exp_wb && v.wb_m[l] && v.wb_w == v.iss_w && v.wb_a == rs)
          r[l*DW +: DW] = v.wb_d[l*DW +: DW];
        else
          r[l*DW +: DW] = ref_mem[v.iss_w][rs][l];
      end
    end
    return r;
  endfunction

  task automatic check_out(input logic rdy);
    if (sb.size() != 0) begin
      chk("op_valid", BW'(op_valid), BW'(1'b1));
      chk("op_warp", BW'(op_warp), BW'(sb[0].warp));
      chk("op_mask", BW'(op_mask), BW'(sb[0].mask));
      chk("op_data_0", op_data_0, sb[0].d0);
      chk("op_data_1", op_data_1, sb[0].d1);
      if (rdy) sb.delete(0);
    end else begin
      chk("op_valid_idle", BW'(op_valid), BW'(1'b0));
    end
  endtask

  task automatic apply(input vec_t v);
    bundle_t b;
    wb_valid = v.wb_v;  wb_warp = v.wb_w;  wb_addr = v.wb_a;  wb_mask = v.wb_m;  wb_data = v.wb_d;
    iss_valid = v.iss_v; iss_warp = v.iss_w; iss_rs0 = v.rs0; iss_rs1 = v.rs1;
    iss_rs0_en = v.en0; iss_rs1_en = v.en1; iss_mask = v.iss_m; op_ready = v.op_rdy;
    @(negedge clk);
    chk("wb_ready", BW'(wb_ready), BW'(v.exp_wb));
    chk("iss_ready", BW'(iss_ready), BW'(v.exp_iss));
    chk("rb_warp_selector", BW'(rb_warp_selector), BW'(v.exp_sel));
    chk("rb_write_en", BW'(rb_write_en), BW'(v.exp_wb ? v.wb_m : 16'h0));
    chk("rb_read_en_0", BW'(rb_read_en_0), BW'((v.exp_iss && v.en0) ? v.iss_m : 16'h0));
    chk("rb_read_en_1", BW'(rb_read_en_1), BW'((v.exp_iss && v.en1) ? v.iss_m : 16'h0));
    check_out(v.op_rdy);
    if (v.exp_iss) begin
      b.warp = v.iss_w;
      b.mask = v.iss_m;
      b.d0   = expect_port(v, v.rs0, v.en0);
      b.d1   = expect_port(v, v.rs1, v.en1);
      sb.push_back(b);
    end
    if (v.exp_wb)
      for (int l = 0; l < NL; l++)
        if (v.wb_m[l]) ref_mem[v.wb_w][v.wb_a][l] = v.wb_d[l*DW +: DW];
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset raised and dropped between clock edges with traffic pending;
  // the write presented here must never reach the reference memory.
  task automatic mid_reset();
    wb_valid = 1'b1; wb_warp = 3'd0; wb_addr = 6'h20; wb_mask = 16'hFFFF;
    wb_data = fill(32'hDEAD_BEEF, 1'b0);
    iss_valid = 1'b1; iss_warp = 3'd0; iss_rs0 = 6'h20; iss_rs1 = 6'h21;
    iss_rs0_en = 1'b1; iss_rs1_en = 1'b0; iss_mask = 16'hFFFF; op_ready = 1'b0;
    #1;
    chk("pre_rst_op_valid", BW'(op_valid), BW'(sb.size() != 0));
    #1 rst = 1'b1;
    #1;
    chk("rst_op_valid", BW'(op_valid), BW'(1'b0));
    chk("rst_iss_ready", BW'(iss_ready), BW'(1'b0));
    chk("rst_wb_ready", BW'(wb_ready), BW'(1'b0));
    chk("rst_rb_write_en", BW'(rb_write_en), BW'(16'h0));
    chk("rst_rb_read_en_0", BW'(rb_read_en_0), BW'(16'h0));
    @(posedge clk);
    #3 rst = 1'b0;
    sb.delete();
    wb_valid = 1'b0; iss_valid = 1'b0; op_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_op_valid", BW'(op_valid), BW'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] d;
    logic [AW-1:0] other;
    rst = 1'b1;
    wb_valid = 1'b0; wb_warp = '0; wb_addr = '0; wb_mask = '0; wb_data = '0;
    iss_valid = 1'b0; iss_warp = '0; iss_rs0 = '0; iss_rs1 = '0;
    iss_rs0_en = 1'b0; iss_rs1_en = 1'b0; iss_mask = '0; op_ready = 1'b0;
    mem_init = 1'b1;
    for (int w = 0; w < 8; w++)
      for (int a = 0; a < 64; a++)
        for (int l = 0; l < NL; l++) ref_mem[w][a][l] = init_val(w, a, l);
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_op_valid", BW'(op_valid), BW'(1'b0));
    chk("reset_op_warp", BW'(op_warp), BW'(3'd0));
    chk("reset_op_mask", BW'(op_mask), BW'(16'h0));
    chk("reset_op_data_0", op_data_0, '0);
    chk("reset_op_data_1", op_data_1, '0);
    chk("reset_rb_warp_selector", BW'(rb_warp_selector), BW'(3'd0));
    @(posedge clk);
    #1;

    // Write-then-read, same-cycle bypass, partial masks
    tbl.push_back(mk(1'b1, 3'd3, 6'h05, 16'hFFFF, fill(32'hA5A5_0000, 1'b1),
                     1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 3'd3));
    tbl.push_back(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                     1'b1, 3'd3, 6'h05, 6'h00, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 3'd3));
    tbl.push_back(mk(1'b1, 3'd2, 6'h10, 16'hFFFF, fill(32'h2222_2222, 1'b0),
                     1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 3'd2));
    tbl.push_back(mk(1'b1, 3'd2, 6'h10, 16'h00FF, fill(32'h1111_1111, 1'b0),
                     1'b1, 3'd2, 6'h10, 6'h10, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 3'd2));
    tbl.push_back(idle(3'd2));
    tbl.push_back(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                     1'b1, 3'd3, 6'h05, 6'h3F, 1'b1, 1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b1, 3'd3));
    tbl.push_back(idle(3'd3));
    // Cross-warp conflict: four write wins, then the read is forced through
    for (int i = 0; i < 10; i++) tbl.push_back(conflict_vec(i % 5 == 4));
    tbl.push_back(idle(3'd6));
    // Backpressure: bundle held ten cycles, then replaced without a bubble
    tbl.push_back(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                     1'b1, 3'd4, 6'h02, 6'h03, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'd4));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                       1'b1, 3'd5, 6'h09, 6'h0A, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 3'd4));
    tbl.push_back(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                     1'b1, 3'd5, 6'h09, 6'h0A, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, 3'd5));
    tbl.push_back(idle(3'd5));
    foreach (tbl[i]) apply(tbl[i]);

    // Reset while a bundle is waiting; the write presented during reset is dropped
    apply(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
             1'b1, 3'd0, 6'h20, 6'h00, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 3'd0));
    mid_reset();
    apply(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
             1'b1, 3'd0, 6'h20, 6'h00, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, 3'd0));
    apply(idle(3'd0));

    // Reset with a partly built starvation count; full count must restart
    for (int i = 0; i < 3; i++) apply(conflict_vec(1'b0));
    mid_reset();
    for (int i = 0; i < 5; i++) apply(conflict_vec(i == 4));
    apply(idle(3'd6));

    // Sweep: every warp/register written, then read on port 0, port 1 and both
    for (int w = 0; w < 8; w++) begin
      for (int a = 0; a < 64; a++) begin
        for (int l = 0; l < NL; l++) d[l*DW +: DW] = $urandom();
        other = AW'(a) ^ 6'h15;
        apply(mk(1'b1, WW'(w), AW'(a), 16'hFFFF, d,
                 1'b0, 3'd0, 6'h00, 6'h00, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, WW'(w)));
        apply(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                 1'b1, WW'(w), AW'(a), other, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b1, WW'(w)));
        apply(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                 1'b1, WW'(w), other, AW'(a), 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, WW'(w)));
        apply(mk(1'b0, 3'd0, 6'h00, 16'h0, '0,
                 1'b1, WW'(w), AW'(a), AW'(a), 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1, WW'(w)));
      end
    end
    apply(idle(3'd7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_access_ctrl.md
Name: reg_access_ctrl

Overview:
- Initiator-side controller for register_block (16 lanes x 64 regs x 32 b, 8 warps, read ports 0/1, one write port, shared warp_selector).
- Accepts operand-read requests from issue and writeback requests from execute.
- Arbitrates them onto register_block's single warp_selector and drives its read/write ports.
- Forwards same-cycle write data, and presents captured operands to execute through a one-entry valid/ready output register.

Parameters:
NUM_LANES, 16, lanes per warp
ADDR_W, 6, register address width (64 regs)
DATA_W, 32, bits per lane
WARP_W, 3, warp id width (8 warps)
STARVE_LIMIT, 4, consecutive conflict-denied read cycles before a read is forced through

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
iss_valid  in  1  operand-read request valid
iss_ready  out  1  read request accepted this cycle
iss_warp  in  WARP_W  warp of read request
iss_mask  in  NUM_LANES  active lanes
iss_rs0, iss_rs1  in  ADDR_W  source register addresses
iss_rs0_en, iss_rs1_en  in  1  source used
wb_valid  in  1  writeback valid
wb_ready  out  1  writeback accepted this cycle
wb_warp  in  WARP_W  writeback warp
wb_mask  in  NUM_LANES  lanes to write
wb_addr  in  ADDR_W  destination register
wb_data  in  NUM_LANES*DATA_W  lane l at [l*DATA_W +: DATA_W]
rb_read_en_0, rb_read_en_1  out  NUM_LANES  to register_block read_en_0/1
rb_raddr_0, rb_raddr_1  out  ADDR_W  to raddr_0/1
rb_write_en  out  NUM_LANES  to write_en
rb_waddr  out  ADDR_W  to waddr
rb_wdata  out  NUM_LANES*DATA_W  to wdata_0..15 (packed)
rb_warp_selector  out  WARP_W  to warp_selector
rb_rdata_0, rb_rdata_1  in  NUM_LANES*DATA_W  from rdata_0_*/rdata_1_* (packed)
op_valid  out  1  operand bundle valid
op_ready  in  1  execute accepts bundle
op_warp  out  WARP_W  warp of bundle
op_mask  out  NUM_LANES  lane mask of bundle
op_data_0, op_data_1  out  NUM_LANES*DATA_W  operands

Behaviour:
- register_block timing: reads are combinational within a cycle; writes commit at the rising edge.
- Slot free: `slot_free = !op_valid || op_ready`.
- Conflict: `wb_valid && iss_valid && slot_free && wb_warp != iss_warp`.
- Write grant: `wb_ready = wb_valid && !(conflict && starve_cnt == STARVE_LIMIT)`.
- Read grant:
  - `iss_ready = iss_valid && slot_free && (!wb_ready || wb_warp == iss_warp)`.
  - Same-warp read and write are granted in the same cycle.
- starve_cnt:
  - Increments on each cycle where conflict holds and the read loses.
  - Clears on any read grant, and on any cycle with no conflict.
  - Saturates at STARVE_LIMIT.
  - While starve_cnt == STARVE_LIMIT and conflict holds, the read wins and wb_ready = 0.
- rb_warp_selector source, in priority order:
  - wb_warp if write granted.
  - Else iss_warp if read granted.
  - Else last_warp, a register updated on every grant, reset 0.
- Write port:
  - `rb_write_en = wb_ready ? wb_mask : 0`.
  - `rb_waddr = wb_addr`.
  - `rb_wdata = wb_data`.
- Read ports:
  - `rb_read_en_k = (iss_ready && iss_rsk_en) ? iss_mask : 0`.
  - `rb_raddr_k = iss_rsk`.
- Bypass, per lane l and port k: if the write is granted in the same cycle, wb_warp == iss_warp, wb_addr == iss_rsk and wb_mask[l], the captured value is wb_data lane l. Otherwise it is rb_rdata_k lane l.
- Zero fill: lanes not in iss_mask, and ports with rsk_en = 0, capture 0.
- Capture: on a read grant, op_data_0/1, op_warp and op_mask load at the rising edge. op_valid = 1 the next cycle, i.e. 1-cycle latency from acceptance.
- Output register:
  - Holds stable while `op_valid && !op_ready`.
  - op_valid clears on `op_ready` with no new grant.
  - Back-to-back grants give one bundle per cycle.
- Reset (async, any time):
  - op_valid, op_warp, op_mask, op_data_*, starve_cnt and last_warp go to 0.
  - While rst = 1, iss_ready, wb_ready, rb_write_en and rb_read_en_* are forced to 0.
  - An in-flight bundle is discarded.
  - No write is committed during the reset cycle.

Test Plan:
- Reset with op_valid = 1: assert rst mid-cycle -> op_valid, iss_ready, wb_ready and rb_write_en go to 0 immediately; after release op_valid = 0 and starve_cnt = 0.
- Write then read: wb warp 3, addr 0x05, mask 0xFFFF, lane data 0xA5A5_0000+l; next cycle iss warp 3, rs0 = 0x05, rs0_en = 1, rs1_en = 0 -> one cycle later op_valid = 1, op_data_0 lane l = 0xA5A5_0000+l, op_data_1 = 0.
- Same-cycle bypass: wb warp 2, addr 0x10, mask 0x00FF, data 0x1111_1111, together with iss warp 2, rs0 = rs1 = 0x10, mask 0xFFFF; prior contents 0x2222_2222 -> lanes 0-7 = 0x1111_1111 and lanes 8-15 = 0x2222_2222 on both ports; both grants asserted.
- Warp conflict and starvation: continuous wb warp 1 with iss warp 6 and op_ready = 1 -> wb_ready = 1 for 4 cycles with iss_ready = 0; in cycle 5, iss_ready = 1, wb_ready = 0 and rb_warp_selector = 6; pattern then repeats.
- Backpressure: op_ready = 0 with op_valid = 1 -> iss_ready = 0, op_data stable for 10 cycles; raise op_ready with iss_valid = 1 -> new bundle replaces the old one in the same cycle, with no bubble.
- Sweep all 8 warps x 64 registers with random data and full mask: write, then read via port 0, port 1, then both -> all 16 lanes match on both ports.
